// File: rtl/isa_types.sv
// Shared ISA types for the fetch/decode path: datapath widths, fetch FSM
// encoding, instruction-buffer entry layout and the opcode extraction helper.
package isa_types;

    localparam int XLEN = 32;
    localparam int ILEN = 32;
    parameter int INSTR_ALIGN_BITS = 2;

    typedef enum logic [1:0] {
        FETCH_REQ  = 2'd0,
        FETCH_WAIT = 2'd1,
        FETCH_DROP = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [ILEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic            misaligned;
    } fetch_entry_t;

    function automatic logic [6:0] opcode_of(input logic [ILEN-1:0] word);
        return word[6:0];
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Show-ahead instruction buffer of fetch_entry_t with synchronous flush.
// The head is read straight from registered storage and zeroed when empty.
module fetch_fifo
    import isa_types::*;
#(
    parameter int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               push,
    input  fetch_entry_t       push_data,
    input  logic               pop,
    output logic               head_valid,
    output fetch_entry_t       head_data,
    output logic [CNT_W-1:0]   count
);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_pop;

    assign head_valid = (count != '0);
    assign head_data  = head_valid ? mem[rd_ptr] : '0;
    assign do_pop     = pop && head_valid;

    // Push while full is legal only alongside a pop; the upstream slot reservation guarantees it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: sequential fetch with one outstanding request,
// show-ahead buffer, redirect flush/squash. Optional macro FETCH_MISALIGN_CHECK_EN.
//
// state      | meaning
// FETCH_REQ  | may issue a request when a buffer slot is free
// FETCH_WAIT | request accepted, response will be pushed
// FETCH_DROP | request accepted before a redirect, response will be discarded
module instr_fetch_unit
    import isa_types::*;
#(
    parameter int               XLEN       = isa_types::XLEN,
    parameter logic [XLEN-1:0]  RESET_PC   = '0,
    parameter int               FIFO_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             mem_req_valid,
    output logic [XLEN-1:0]  mem_req_addr,
    input  logic             mem_req_ready,
    input  logic             mem_rsp_valid,
    input  logic [ILEN-1:0]  mem_rsp_data,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_pc,
    output logic             instr_valid,
    output logic [ILEN-1:0]  instr_bits,
    output logic [XLEN-1:0]  instr_pc,
    input  logic             instr_ready,
    output logic             instr_misaligned
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t     state_q, state_d;
    logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]  req_pc_q, req_pc_d;
    logic             started_q;
    logic             rsp_push;
    logic             pop;
    logic             mis_push;
    logic [CNT_W-1:0] fifo_count;
    fetch_entry_t     push_entry;
    fetch_entry_t     head_entry;

    // started_q keeps the request channel quiet during the reset cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FETCH_REQ;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= RESET_PC;
            started_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            started_q  <= 1'b1;
        end
    end

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        req_pc_d      = req_pc_q;
        mem_req_valid = 1'b0;
        rsp_push      = 1'b0;

        unique case (state_q)
            FETCH_REQ: begin
                mem_req_valid = started_q && (fifo_count < CNT_W'(FIFO_DEPTH));
                if (mem_req_valid && mem_req_ready) begin
                    req_pc_d   = fetch_pc_q;
                    fetch_pc_d = fetch_pc_q + XLEN'(4);
                    state_d    = FETCH_WAIT;
                end
            end
            FETCH_WAIT: begin
                if (mem_rsp_valid) begin
                    rsp_push = 1'b1;
                    state_d  = FETCH_REQ;
                end
            end
            FETCH_DROP: begin
                if (mem_rsp_valid) begin
                    state_d = FETCH_REQ;
                end
            end
            default: state_d = FETCH_REQ;
        endcase

        // A response landing in the redirect cycle is the outstanding one, so no drop is needed.
        if (redirect_valid) begin
            rsp_push   = 1'b0;
            fetch_pc_d = {redirect_pc[XLEN-1:INSTR_ALIGN_BITS], {INSTR_ALIGN_BITS{1'b0}}};
            if ((state_q == FETCH_REQ && mem_req_valid && mem_req_ready) ||
                (state_q != FETCH_REQ && !mem_rsp_valid)) begin
                state_d = FETCH_DROP;
            end else begin
                state_d = FETCH_REQ;
            end
        end
    end

    assign mem_req_addr = fetch_pc_q;
    assign pop          = instr_valid && instr_ready;

    assign push_entry.instr      = mem_rsp_data;
    assign push_entry.pc         = req_pc_q;
    assign push_entry.misaligned = mis_push;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic misalign_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_q <= 1'b0;
        end else if (redirect_valid) begin
            misalign_q <= |redirect_pc[INSTR_ALIGN_BITS-1:0];
        end else if (rsp_push) begin
            misalign_q <= 1'b0;
        end
    end

    assign mis_push         = misalign_q;
    assign instr_misaligned = head_entry.misaligned;
`else
    logic unused_misalign;

    assign unused_misalign  = ^{redirect_pc[INSTR_ALIGN_BITS-1:0], head_entry.misaligned};
    assign mis_push         = 1'b0;
    assign instr_misaligned = 1'b0;
`endif

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (redirect_valid),
        .push       (rsp_push),
        .push_data  (push_entry),
        .pop        (pop),
        .head_valid (instr_valid),
        .head_data  (head_entry),
        .count      (fifo_count)
    );

    assign instr_bits = head_entry.instr;
    assign instr_pc   = head_entry.pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus a randomized
// run against a sequential-PC stream model with a latency-programmable memory.
module tb_instr_fetch_unit;
    import isa_types::*;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef FETCH_MISALIGN_CHECK_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_req_ready;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr_bits;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        instr_misaligned;

    instr_fetch_unit #(.XLEN(32), .RESET_PC(RESET_PC), .FIFO_DEPTH(2)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .mem_req_valid    (mem_req_valid),
        .mem_req_addr     (mem_req_addr),
        .mem_req_ready    (mem_req_ready),
        .mem_rsp_valid    (mem_rsp_valid),
        .mem_rsp_data     (mem_rsp_data),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .instr_valid      (instr_valid),
        .instr_bits       (instr_bits),
        .instr_pc         (instr_pc),
        .instr_ready      (instr_ready),
        .instr_misaligned (instr_misaligned)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // memory model state and per-cycle observations
    bit          mem_pend = 1'b0;
    int          mem_cnt = 0;
    logic [31:0] mem_addr = '0;
    int          mem_lat = 1;
    bit          acc, pop, rsp_fire, overlap;
    logic [31:0] acc_addr, pop_pc, pop_bits;
    logic        pop_mis;

    // One clock cycle: drive inputs at posedge+1, record what the cycle does, advance.
    task automatic drive(input bit rdy, input bit irdy, input bit redir, input logic [31:0] rpc);
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = 32'hDEAD_BEEF;
        if (mem_pend) begin
            if (mem_cnt == 0) begin
                mem_rsp_valid = 1'b1;
                mem_rsp_data  = mem_addr ^ 32'h0000_0013;
                mem_pend      = 1'b0;
            end else begin
                mem_cnt--;
            end
        end
        mem_req_ready  = rdy;
        instr_ready    = irdy;
        redirect_valid = redir;
        redirect_pc    = rpc;
        rsp_fire = mem_rsp_valid;
        acc      = mem_req_valid && rdy;
        acc_addr = mem_req_addr;
        pop      = instr_valid && irdy;
        pop_pc   = instr_pc;
        pop_bits = instr_bits;
        pop_mis  = instr_misaligned;
        overlap  = 1'b0;
        if (acc) begin
            overlap  = mem_pend;
            mem_pend = 1'b1;
            mem_addr = mem_req_addr;
            mem_cnt  = mem_lat - 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n    = 1'b0;
        mem_pend = 1'b0;
        drive(0, 0, 0, '0);
        drive(0, 0, 0, '0);
        rst_n = 1'b1;
        drive(0, 0, 0, '0);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_data = '0;
        redirect_valid = 0; redirect_pc = '0; instr_ready = 0;
        @(posedge clk);
        #1;
        vectors++; if (mem_req_valid !== 1'b0) begin miscompares++; $display("FAIL rst_req_valid got %b want 0", mem_req_valid); end
        vectors++; if (mem_req_addr !== RESET_PC) begin miscompares++; $display("FAIL rst_req_addr got %h want %h", mem_req_addr, RESET_PC); end
        vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL rst_instr_valid got %b want 0", instr_valid); end
        vectors++; if (instr_bits !== 32'h0) begin miscompares++; $display("FAIL rst_instr_bits got %h want 0", instr_bits); end
        vectors++; if (instr_pc !== 32'h0) begin miscompares++; $display("FAIL rst_instr_pc got %h want 0", instr_pc); end
        vectors++; if (instr_misaligned !== 1'b0) begin miscompares++; $display("FAIL rst_misaligned got %b want 0", instr_misaligned); end
        rst_n = 1'b1;
        drive(0, 0, 0, '0);
        vectors++; if (mem_req_valid !== 1'b1) begin miscompares++; $display("FAIL post_rst_req_valid got %b want 1", mem_req_valid); end
        vectors++; if (mem_req_addr !== RESET_PC) begin miscompares++; $display("FAIL post_rst_req_addr got %h want %h", mem_req_addr, RESET_PC); end
    endtask

    task automatic test_stream;
        logic [31:0] reqs[$];
        logic [31:0] pcs[$];
        logic [31:0] bq[$];
        int          pcyc[$];
        do_reset();
        mem_lat = 1;
        for (int i = 0; i < 12; i++) begin
            drive(1, 1, 0, '0);
            if (acc) reqs.push_back(acc_addr);
            if (pop) begin pcs.push_back(pop_pc); bq.push_back(pop_bits); pcyc.push_back(i); end
        end
        vectors++;
        if (reqs.size() < 3 || pcs.size() < 4) begin
            miscompares++;
            $display("FAIL stream_count reqs %0d pops %0d want >=3 and >=4", reqs.size(), pcs.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                vectors++;
                if (reqs[k] !== 32'(k * 4)) begin miscompares++; $display("FAIL stream_req%0d got %h want %h", k, reqs[k], 32'(k * 4)); end
                vectors++;
                if (pcs[k] !== 32'(k * 4) || bq[k] !== (32'(k * 4) ^ 32'h13)) begin
                    miscompares++;
                    $display("FAIL stream_instr%0d got pc %h bits %h want pc %h bits %h", k, pcs[k], bq[k], 32'(k * 4), 32'(k * 4) ^ 32'h13);
                end
            end
            for (int k = 1; k < 4; k++) begin
                vectors++;
                if (pcyc[k] - pcyc[k-1] != 2) begin miscompares++; $display("FAIL stream_cadence%0d got %0d want 2", k, pcyc[k] - pcyc[k-1]); end
            end
        end
    endtask

    task automatic test_backpressure;
        int          n_acc = 0;
        bit          got_req = 0;
        logic [31:0] first_req = '0;
        logic [31:0] pcs[$];
        do_reset();
        mem_lat = 1;
        for (int i = 0; i < 10; i++) begin
            drive(1, 0, 0, '0);
            if (acc) n_acc++;
        end
        vectors++; if (n_acc != 2) begin miscompares++; $display("FAIL bp_req_count got %0d want 2", n_acc); end
        vectors++; if (mem_req_valid !== 1'b0) begin miscompares++; $display("FAIL bp_req_stalled got %b want 0", mem_req_valid); end
        for (int i = 0; i < 10; i++) begin
            drive(1, 1, 0, '0);
            if (acc && !got_req) begin got_req = 1; first_req = acc_addr; end
            if (pop) pcs.push_back(pop_pc);
        end
        vectors++; if (!got_req || first_req !== 32'h8) begin miscompares++; $display("FAIL bp_resume_addr got %h want 00000008", first_req); end
        vectors++;
        if (pcs.size() < 3) begin
            miscompares++; $display("FAIL bp_pops got %0d entries want >=3", pcs.size());
        end else if (pcs[0] !== 32'h0 || pcs[1] !== 32'h4 || pcs[2] !== 32'h8) begin
            miscompares++; $display("FAIL bp_pop_order got %h %h %h want 0 4 8", pcs[0], pcs[1], pcs[2]);
        end
    endtask

    task automatic test_redirect_drop;
        bit          found = 0, bad = 0, got_pop = 0, got_req = 0;
        logic [31:0] first_pc = '0, first_bits = '0, first_req = '0;
        do_reset();
        mem_lat = 4;
        for (int i = 0; i < 20 && !found; i++) begin
            drive(1, 1, 0, '0);
            if (acc && acc_addr == 32'h4) found = 1;
        end
        vectors++; if (!found) begin miscompares++; $display("FAIL drop_setup no request to 00000004 within budget"); end
        mem_lat = 1;
        drive(1, 1, 1, 32'h100);
        vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL drop_flush instr_valid got %b want 0", instr_valid); end
        for (int i = 0; i < 25; i++) begin
            drive(1, 1, 0, '0);
            if (acc && !got_req) begin got_req = 1; first_req = acc_addr; end
            if (pop) begin
                if (pop_pc == 32'h4) bad = 1;
                if (!got_pop) begin got_pop = 1; first_pc = pop_pc; first_bits = pop_bits; end
            end
        end
        vectors++; if (bad) begin miscompares++; $display("FAIL drop_squash entry with pc 00000004 appeared, want none"); end
        vectors++; if (!got_req || first_req !== 32'h100) begin miscompares++; $display("FAIL drop_req got %h want 00000100", first_req); end
        vectors++;
        if (!got_pop || first_pc !== 32'h100 || first_bits !== 32'h113) begin
            miscompares++; $display("FAIL drop_first_instr got pc %h bits %h want pc 00000100 bits 00000113", first_pc, first_bits);
        end
    endtask

    task automatic test_redirect_coincident;
        bit          found = 0, got_req = 0;
        logic [31:0] first_req = '0;
        do_reset();
        mem_lat = 1;
        for (int i = 0; i < 20 && !found; i++) begin
            if (mem_pend && mem_cnt == 0 && instr_valid) found = 1;
            else drive(1, 0, 0, '0);
        end
        vectors++; if (!found) begin miscompares++; $display("FAIL coin_setup no pop+push cycle within budget"); end
        drive(1, 1, 1, 32'h200);
        vectors++; if (!(pop && rsp_fire)) begin miscompares++; $display("FAIL coin_event got pop %b rsp %b want 1 1", pop, rsp_fire); end
        vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL coin_flush instr_valid got %b want 0", instr_valid); end
        for (int i = 0; i < 10 && !got_req; i++) begin
            drive(1, 1, 0, '0);
            if (acc) begin got_req = 1; first_req = acc_addr; end
        end
        vectors++; if (!got_req || first_req !== 32'h200) begin miscompares++; $display("FAIL coin_req got %h want 00000200", first_req); end
    endtask

    task automatic test_reset_in_wait;
        bit          found = 0, got_pop = 0, stale_ok = 1;
        logic [31:0] first_pc = '0, first_bits = '0;
        do_reset();
        mem_lat = 5;
        for (int i = 0; i < 10 && !found; i++) begin
            drive(1, 1, 0, '0);
            if (acc) found = 1;
        end
        drive(1, 1, 0, '0);
        rst_n = 1'b0;
        drive(0, 0, 0, '0);
        drive(0, 0, 0, '0);
        rst_n = 1'b1;
        for (int i = 0; i < 10 && mem_pend; i++) drive(0, 1, 0, '0);
        vectors++; if (!found || mem_pend) begin miscompares++; $display("FAIL rw_setup stale response not delivered (found %b pend %b)", found, mem_pend); end
        for (int i = 0; i < 3; i++) begin
            if (instr_valid !== 1'b0) stale_ok = 0;
            drive(0, 1, 0, '0);
        end
        vectors++; if (!stale_ok) begin miscompares++; $display("FAIL rw_stale instr_valid rose after stale response, want 0"); end
        vectors++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== RESET_PC) begin
            miscompares++; $display("FAIL rw_req got valid %b addr %h want 1 %h", mem_req_valid, mem_req_addr, RESET_PC);
        end
        mem_lat = 1;
        for (int i = 0; i < 10 && !got_pop; i++) begin
            drive(1, 1, 0, '0);
            if (pop) begin got_pop = 1; first_pc = pop_pc; first_bits = pop_bits; end
        end
        vectors++;
        if (!got_pop || first_pc !== RESET_PC || first_bits !== (RESET_PC ^ 32'h13)) begin
            miscompares++; $display("FAIL rw_first_instr got pc %h bits %h want pc %h bits %h", first_pc, first_bits, RESET_PC, RESET_PC ^ 32'h13);
        end
    endtask

    task automatic test_misalign;
        bit          got_req = 0;
        logic [31:0] first_req = '0;
        logic [31:0] pcs[$];
        logic        mis[$];
        do_reset();
        mem_lat = 1;
        drive(0, 1, 1, 32'h102);
        for (int i = 0; i < 20; i++) begin
            drive(1, 1, 0, '0);
            if (acc && !got_req) begin got_req = 1; first_req = acc_addr; end
            if (pop) begin pcs.push_back(pop_pc); mis.push_back(pop_mis); end
        end
        vectors++; if (!got_req || first_req !== 32'h100) begin miscompares++; $display("FAIL mis_req got %h want 00000100", first_req); end
        vectors++;
        if (pcs.size() < 3) begin
            miscompares++; $display("FAIL mis_pops got %0d entries want >=3", pcs.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                vectors++;
                if (pcs[k] !== 32'h100 + 32'(4 * k) || mis[k] !== ((k == 0) ? MIS_EN : 1'b0)) begin
                    miscompares++;
                    $display("FAIL mis_entry%0d got pc %h mis %b want pc %h mis %b", k, pcs[k], mis[k], 32'h100 + 32'(4 * k), (k == 0) ? MIS_EN : 1'b0);
                end
            end
        end
    endtask

    task automatic test_random;
        logic [31:0] exp_req, exp_pc, rpc;
        bit          exp_mis, rdy, irdy, redir;
        int          n_pop = 0;
        do_reset();
        exp_req = RESET_PC;
        exp_pc  = RESET_PC;
        exp_mis = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            rdy     = ($urandom_range(0, 3) != 0);
            irdy    = ($urandom_range(0, 2) != 0);
            redir   = ($urandom_range(0, 19) == 0);
            rpc     = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            mem_lat = $urandom_range(1, 4);
            drive(rdy, irdy, redir, rpc);
            if (acc) begin
                vectors++;
                if (overlap || acc_addr !== exp_req) begin
                    miscompares++; $display("FAIL rnd_req cyc %0d got %h overlap %b want %h", i, acc_addr, overlap, exp_req);
                end
                exp_req = exp_req + 32'd4;
            end
            if (pop && !redir) begin
                vectors++;
                if (pop_pc !== exp_pc || pop_bits !== (exp_pc ^ 32'h13) || pop_mis !== exp_mis) begin
                    miscompares++;
                    $display("FAIL rnd_instr cyc %0d got pc %h bits %h mis %b want pc %h bits %h mis %b",
                             i, pop_pc, pop_bits, pop_mis, exp_pc, exp_pc ^ 32'h13, exp_mis);
                end
                exp_pc  = exp_pc + 32'd4;
                exp_mis = 1'b0;
                n_pop++;
            end
            if (redir) begin
                exp_req = {rpc[31:2], 2'b00};
                exp_pc  = exp_req;
                exp_mis = MIS_EN && (rpc[1:0] != 2'b00);
                vectors++;
                if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL rnd_flush cyc %0d instr_valid got %b want 0", i, instr_valid); end
            end
        end
        vectors++; if (n_pop < 300) begin miscompares++; $display("FAIL rnd_progress got %0d instructions want >=300", n_pop); end
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_drop();
        test_redirect_coincident();
        test_reset_in_wait();
        test_misalign();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
